// File: rtl/calc_req_collector.sv
// Request collector: assembles two-cycle calculator requests, tracks busy tags,
// queues accepted requests in-order for the ALU and raises local responses/errors.
module calc_req_collector #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic [3:0]        req_cmd_in,
   input  logic [DATA_W-1:0] req_data_in,
   input  logic [1:0]        req_tag_in,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [3:0]        issue_cmd,
   output logic [DATA_W-1:0] issue_op1,
   output logic [DATA_W-1:0] issue_op2,
   output logic [1:0]        issue_tag,
   input  logic              done_valid,
   input  logic [1:0]        done_tag,
   output logic              lresp_valid,
   output logic [1:0]        lresp,
   output logic [1:0]        lresp_tag,
   output logic              dup_err,
   output logic              proto_err,
   output logic [2:0]        outstanding
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned NTAGS = 4;

   localparam logic [3:0] CMD_NOP = 4'b0000;
   localparam logic [3:0] CMD_ADD = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_LSH = 4'b0101;
   localparam logic [3:0] CMD_RSH = 4'b0110;

   localparam logic [1:0] RESP_NORE = 2'b00;
   localparam logic [1:0] RESP_INVL = 2'b10;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DATA2 = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [1:0]        tag;
   } entry_t;

   state_t              state_q, state_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [1:0]          tag_q, tag_d;
   logic [DATA_W-1:0]   op1_q, op1_d;

   entry_t              fifo_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [NTAGS-1:0]    busy_q, busy_d;
   logic [2:0]          outstanding_q, outstanding_d;

   logic                lresp_valid_q, lresp_valid_d;
   logic [1:0]          lresp_q, lresp_d;
   logic [1:0]          lresp_tag_q, lresp_tag_d;
   logic                dup_err_q, dup_err_d;
   logic                proto_err_q, proto_err_d;

   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic                cmd_is_alu;
   logic                tag_busy;
   entry_t              push_entry;
   entry_t              head;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign pop        = !fifo_empty && issue_ready;

   assign cmd_is_alu = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB) ||
                       (cmd_q == CMD_LSH) || (cmd_q == CMD_RSH);

   // A retire landing in the same cycle frees the tag for the request being classified.
   assign tag_busy = busy_q[tag_q] && !(done_valid && (done_tag == tag_q));

   assign push_entry = '{cmd: cmd_q, op1: op1_q, op2: req_data_in, tag: tag_q};

   // State register and request capture
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         tag_q   <= '0;
         op1_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         tag_q   <= tag_d;
         op1_q   <= op1_d;
      end
   end

   // Next-state, classification and local response generation
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      tag_d         = tag_q;
      op1_d         = op1_q;
      push          = 1'b0;
      lresp_valid_d = 1'b0;
      lresp_d       = RESP_NORE;
      lresp_tag_d   = '0;
      dup_err_d     = 1'b0;
      proto_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_cmd_in != CMD_NOP) begin
               cmd_d   = req_cmd_in;
               tag_d   = req_tag_in;
               op1_d   = req_data_in;
               state_d = S_DATA2;
            end
         end
         S_DATA2: begin
            state_d     = S_IDLE;
            proto_err_d = (req_cmd_in != CMD_NOP);
            if (!cmd_is_alu) begin
               lresp_valid_d = 1'b1;
               lresp_d       = RESP_INVL;
               lresp_tag_d   = tag_q;
            end else if (tag_busy) begin
               dup_err_d = 1'b1;
            end else if (!fifo_full) begin
               push = 1'b1;
            end
         end
      endcase
   end

   // FIFO pointer/count and tag scoreboard next values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      busy_d   = busy_q;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (done_valid) begin
         busy_d[done_tag] = 1'b0;
      end
      if (push) begin
         busy_d[tag_q] = 1'b1;
      end

      outstanding_d = '0;
      for (int i = 0; i < NTAGS; i++) begin
         outstanding_d = outstanding_d + 3'(busy_d[i]);
      end
   end

   // FIFO storage, scoreboard and registered status outputs
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         busy_q        <= '0;
         outstanding_q <= '0;
         lresp_valid_q <= 1'b0;
         lresp_q       <= RESP_NORE;
         lresp_tag_q   <= '0;
         dup_err_q     <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
         end
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         busy_q        <= busy_d;
         outstanding_q <= outstanding_d;
         lresp_valid_q <= lresp_valid_d;
         lresp_q       <= lresp_d;
         lresp_tag_q   <= lresp_tag_d;
         dup_err_q     <= dup_err_d;
         proto_err_q   <= proto_err_d;
      end
   end

   // Head presentation is forced to zero while the queue is empty.
   assign head        = fifo_q[rd_ptr_q];
   assign issue_valid = !fifo_empty;
   assign issue_cmd   = fifo_empty ? '0 : head.cmd;
   assign issue_op1   = fifo_empty ? '0 : head.op1;
   assign issue_op2   = fifo_empty ? '0 : head.op2;
   assign issue_tag   = fifo_empty ? '0 : head.tag;

   assign lresp_valid = lresp_valid_q;
   assign lresp       = lresp_q;
   assign lresp_tag   = lresp_tag_q;
   assign dup_err     = dup_err_q;
   assign proto_err   = proto_err_q;
   assign outstanding = outstanding_q;

endmodule

// File: tb/tb_calc_req_collector.sv
// Directed self-checking bench for calc_req_collector.
module tb_calc_req_collector;

   localparam int unsigned DW = 32;

   localparam logic [3:0] NOP = 4'b0000;
   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SUB = 4'b0010;
   localparam logic [3:0] LSH = 4'b0101;
   localparam logic [3:0] RSH = 4'b0110;

   logic          c_clk = 1'b0;
   logic          reset;
   logic [3:0]    req_cmd_in;
   logic [DW-1:0] req_data_in;
   logic [1:0]    req_tag_in;
   logic          issue_valid;
   logic          issue_ready;
   logic [3:0]    issue_cmd;
   logic [DW-1:0] issue_op1;
   logic [DW-1:0] issue_op2;
   logic [1:0]    issue_tag;
   logic          done_valid;
   logic [1:0]    done_tag;
   logic          lresp_valid;
   logic [1:0]    lresp;
   logic [1:0]    lresp_tag;
   logic          dup_err;
   logic          proto_err;
   logic [2:0]    outstanding;

   int errors = 0;
   int checks = 0;

   calc_req_collector #(.DATA_W(DW), .DEPTH(4)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_cmd   (issue_cmd),
      .issue_op1   (issue_op1),
      .issue_op2   (issue_op2),
      .issue_tag   (issue_tag),
      .done_valid  (done_valid),
      .done_tag    (done_tag),
      .lresp_valid (lresp_valid),
      .lresp       (lresp),
      .lresp_tag   (lresp_tag),
      .dup_err     (dup_err),
      .proto_err   (proto_err),
      .outstanding (outstanding)
   );

   always #5 c_clk = ~c_clk;

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Command cycle then operand2 cycle; returns at the sample point of T+2.
   task automatic send(input logic [3:0] c, input logic [1:0] t,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [3:0] c2);
      req_cmd_in  = c;
      req_tag_in  = t;
      req_data_in = d1;
      tick();
      req_cmd_in  = c2;
      req_data_in = d2;
      tick();
      req_cmd_in  = NOP;
      req_data_in = '0;
   endtask

   task automatic retire(input logic [1:0] t);
      done_valid = 1'b1;
      done_tag   = t;
      tick();
      done_valid = 1'b0;
      done_tag   = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
      checks++; if ({issue_cmd, issue_op1, issue_op2, issue_tag} !== '0) begin errors++; $display("FAIL reset_issue_fields: got %h/%h/%h/%h want 0", issue_cmd, issue_op1, issue_op2, issue_tag); end
      checks++; if ({lresp_valid, lresp, lresp_tag} !== 5'b0) begin errors++; $display("FAIL reset_lresp: got %b/%b/%b want 0", lresp_valid, lresp, lresp_tag); end
      checks++; if ({dup_err, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b%b want 00", dup_err, proto_err); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
      reset = 1'b0;
   endtask

   task automatic test_add();
      issue_ready = 1'b1;
      req_cmd_in  = ADD;
      req_tag_in  = 2'd1;
      req_data_in = 32'd5;
      tick();
      req_cmd_in  = NOP;
      req_data_in = 32'd7;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0 at T+1", issue_valid); end
      tick();
      req_data_in = '0;
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", issue_valid); end
      checks++; if (issue_cmd !== ADD) begin errors++; $display("FAIL add_cmd: got %b want 0001", issue_cmd); end
      checks++; if (issue_op1 !== 32'd5) begin errors++; $display("FAIL add_op1: got %0d want 5", issue_op1); end
      checks++; if (issue_op2 !== 32'd7) begin errors++; $display("FAIL add_op2: got %0d want 7", issue_op2); end
      checks++; if (issue_tag !== 2'd1) begin errors++; $display("FAIL add_tag: got %0d want 1", issue_tag); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL add_outstanding: got %0d want 1", outstanding); end
      tick();
      checks++; if ({issue_valid, issue_cmd, issue_op1} !== '0) begin errors++; $display("FAIL add_popped_zero: got %b/%h/%h want 0", issue_valid, issue_cmd, issue_op1); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL add_busy_after_pop: got %0d want 1", outstanding); end
      retire(2'd1);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL add_retire: got %0d want 0", outstanding); end
      retire(2'd2);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL add_retire_free: got %0d want 0", outstanding); end
      issue_ready = 1'b0;
   endtask

   task automatic test_invalid_cmd();
      send(4'b0011, 2'd2, 32'd1, 32'd2, NOP);
      checks++; if (lresp_valid !== 1'b1) begin errors++; $display("FAIL invl_valid: got %b want 1", lresp_valid); end
      checks++; if (lresp !== 2'b10) begin errors++; $display("FAIL invl_code: got %b want 10", lresp); end
      checks++; if (lresp_tag !== 2'd2) begin errors++; $display("FAIL invl_tag: got %0d want 2", lresp_tag); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL invl_no_push: got %b want 0", issue_valid); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL invl_outstanding: got %0d want 0", outstanding); end
      tick();
      checks++; if ({lresp_valid, lresp} !== 3'b000) begin errors++; $display("FAIL invl_one_cycle: got %b/%b want 0/00", lresp_valid, lresp); end
   endtask

   task automatic test_back_to_back_dup();
      logic [1:0]    exp_tag [4];
      logic [DW-1:0] exp_op1 [4];
      logic [DW-1:0] exp_op2 [4];
      exp_tag = '{2'd1, 2'd2, 2'd3, 2'd2};
      exp_op1 = '{32'd11, 32'd12, 32'd13, 32'd42};
      exp_op2 = '{32'd21, 32'd22, 32'd23, 32'd43};
      issue_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(ADD, 2'(i), 32'(10 + i), 32'(20 + i), NOP);
      end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL fill_outstanding: got %0d want 4", outstanding); end
      checks++; if ({issue_tag, issue_op1} !== {2'd0, 32'd10}) begin errors++; $display("FAIL fill_head: got tag %0d op1 %0d want 0/10", issue_tag, issue_op1); end
      send(ADD, 2'd2, 32'd99, 32'd99, NOP);
      checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b want 1", dup_err); end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL dup_outstanding: got %0d want 4", outstanding); end
      checks++; if (lresp_valid !== 1'b0) begin errors++; $display("FAIL dup_no_lresp: got %b want 0", lresp_valid); end
      tick();
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_one_cycle: got %b want 0", dup_err); end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      retire(2'd2);
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL dup_retire: got %0d want 3", outstanding); end
      send(ADD, 2'd2, 32'd42, 32'd43, NOP);
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL resend_dup: got %b want 0", dup_err); end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL resend_outstanding: got %0d want 4", outstanding); end
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({issue_valid, issue_tag, issue_op1, issue_op2} !== {1'b1, exp_tag[i], exp_op1[i], exp_op2[i]}) begin
            errors++; $display("FAIL drain_order_%0d: got v%b tag %0d op1 %0d op2 %0d want v1 tag %0d op1 %0d op2 %0d",
                               i, issue_valid, issue_tag, issue_op1, issue_op2, exp_tag[i], exp_op1[i], exp_op2[i]);
         end
         tick();
      end
      checks++; if ({issue_valid, issue_tag, issue_op2} !== '0) begin errors++; $display("FAIL drain_empty: got %b/%0d/%0d want 0", issue_valid, issue_tag, issue_op2); end
      issue_ready = 1'b0;
      for (int t = 0; t < 4; t++) retire(2'(t));
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL drain_retire_all: got %0d want 0", outstanding); end
   endtask

   task automatic test_retire_collision();
      issue_ready = 1'b0;
      send(SUB, 2'd3, 32'd100, 32'd1, NOP);
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL coll_first: got %0d want 1", outstanding); end
      req_cmd_in  = SUB;
      req_tag_in  = 2'd3;
      req_data_in = 32'd200;
      tick();
      req_cmd_in  = NOP;
      req_data_in = 32'd201;
      done_valid  = 1'b1;
      done_tag    = 2'd3;
      tick();
      done_valid  = 1'b0;
      req_data_in = '0;
      checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL coll_dup: got %b want 0", dup_err); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL coll_outstanding: got %0d want 1", outstanding); end
      issue_ready = 1'b1;
      tick();
      checks++; if ({issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag} !== {1'b1, SUB, 32'd200, 32'd201, 2'd3}) begin
         errors++; $display("FAIL coll_pushed: got v%b cmd %b op1 %0d op2 %0d tag %0d want v1 0010 200 201 3",
                            issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag);
      end
      tick();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL coll_drained: got %b want 0", issue_valid); end
      issue_ready = 1'b0;
      retire(2'd3);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL coll_retire: got %0d want 0", outstanding); end
   endtask

   task automatic test_reset_mid_request();
      issue_ready = 1'b1;
      req_cmd_in  = LSH;
      req_tag_in  = 2'd0;
      req_data_in = 32'd5;
      tick();
      req_cmd_in  = NOP;
      req_data_in = 32'd6;
      #2 reset = 1'b1;
      tick();
      reset = 1'b0;
      req_data_in = '0;
      tick();
      checks++; if ({issue_valid, lresp_valid, outstanding} !== 5'b0) begin errors++; $display("FAIL rstmid_discard: got v%b lresp %b out %0d want 0", issue_valid, lresp_valid, outstanding); end
      send(ADD, 2'd0, 32'd11, 32'd22, NOP);
      checks++; if ({issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag} !== {1'b1, ADD, 32'd11, 32'd22, 2'd0}) begin
         errors++; $display("FAIL rstmid_next: got v%b cmd %b op1 %0d op2 %0d tag %0d want v1 0001 11 22 0",
                            issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag);
      end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL rstmid_outstanding: got %0d want 1", outstanding); end
      tick();
      issue_ready = 1'b0;
      retire(2'd0);
   endtask

   task automatic test_proto_err();
      issue_ready = 1'b0;
      send(RSH, 2'd1, 32'd9, 32'h33, ADD);
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_pulse: got %b want 1", proto_err); end
      checks++; if ({issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag} !== {1'b1, RSH, 32'd9, 32'h33, 2'd1}) begin
         errors++; $display("FAIL proto_pushed: got v%b cmd %b op1 %0d op2 %h tag %0d want v1 0110 9 33 1",
                            issue_valid, issue_cmd, issue_op1, issue_op2, issue_tag);
      end
      send(ADD, 2'd2, 32'd3, 32'd4, NOP);
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_one_cycle: got %b want 0", proto_err); end
      checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL proto_idle_again: got %0d want 2", outstanding); end
      issue_ready = 1'b1;
      tick();
      checks++; if ({issue_valid, issue_cmd, issue_op1, issue_tag} !== {1'b1, ADD, 32'd3, 2'd2}) begin
         errors++; $display("FAIL proto_second: got v%b cmd %b op1 %0d tag %0d want v1 0001 3 2", issue_valid, issue_cmd, issue_op1, issue_tag);
      end
      tick();
      issue_ready = 1'b0;
      retire(2'd1);
      retire(2'd2);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL proto_retire: got %0d want 0", outstanding); end
   endtask

   initial begin
      reset       = 1'b1;
      req_cmd_in  = NOP;
      req_data_in = '0;
      req_tag_in  = '0;
      issue_ready = 1'b0;
      done_valid  = 1'b0;
      done_tag    = '0;
      test_reset();
      test_add();
      test_invalid_cmd();
      test_back_to_back_dup();
      test_retire_collision();
      test_reset_mid_request();
      test_proto_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/calc_req_collector.md
CALC_REQ_COLLECTOR -- requirements
Module: calc_req_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result data width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning issue FIFO entries (one per tag value).
REQ-003 SHALL have port c_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_cmd_in  input  4  request command (NOP=0000, ADD=0001, SUB=0010, LSH=0101, RSH=0110).
REQ-006 SHALL have port req_data_in  input  DATA_W  operand1 on the command cycle, operand2 on the following cycle.
REQ-007 SHALL have port req_tag_in  input  2  request tag, sampled on the command cycle.
REQ-008 SHALL have port issue_valid  output  1  FIFO head holds a request for the ALU.
REQ-009 SHALL have port issue_ready  input  1  ALU accepts the head this cycle.
REQ-010 SHALL have ports issue_cmd (output, 4), issue_op1 (output, DATA_W), issue_op2 (output, DATA_W) and issue_tag (output, 2), carrying the FIFO head contents.
REQ-011 SHALL have ports done_valid (input, 1) and done_tag (input, 2); a pulse retires the outstanding tag.
REQ-012 SHALL have ports lresp_valid (output, 1), lresp (output, 2) and lresp_tag (output, 2), carrying the locally generated response.
REQ-013 SHALL have port dup_err  output  1  one-cycle pulse on a dropped duplicate-tag request.
REQ-014 SHALL have port proto_err  output  1  one-cycle pulse on a non-NOP cmd during the operand2 cycle.
REQ-015 SHALL have port outstanding  output  3  count of busy tags, range 0..4.

Function
REQ-016 SHALL implement FSM states IDLE and DATA2.
REQ-017 In IDLE, when req_cmd_in != NOP, SHALL capture cmd, tag and operand1 (req_data_in) and go to DATA2; when req_cmd_in == NOP, SHALL stay in IDLE.
REQ-018 In DATA2, SHALL capture req_data_in as operand2 unconditionally, classify the request and return to IDLE.
REQ-019 In DATA2, a non-NOP req_cmd_in SHALL be ignored as a command and SHALL pulse proto_err on the next cycle.
REQ-020 Classification: cmd not in {ADD, SUB, LSH, RSH} -> no push, lresp_valid=1, lresp=INVL(10), lresp_tag=captured tag on the next cycle, for one cycle only.
REQ-021 Classification: valid cmd with busy tag -> request dropped, dup_err pulses on the next cycle, no lresp.
REQ-022 Classification: valid cmd with free tag -> push {cmd, op1, op2, tag} into FIFO and set busy[tag] at the same edge.
REQ-023 Latency: command at cycle T, operand2 at T+1; issue_valid SHALL be 1 no earlier than T+2 when the FIFO was empty.
REQ-024 Pop SHALL occur on a cycle where issue_valid && issue_ready; issue_* SHALL present the new head on the next cycle.
REQ-025 FIFO SHALL be in-order, DEPTH entries, with wrapping read/write pointers; simultaneous push and pop SHALL leave the count unchanged.
REQ-026 FIFO overflow SHALL be impossible (at most 4 tags busy); no push SHALL occur while full.
REQ-027 done_valid with busy[done_tag]=1 SHALL clear busy[done_tag]; done_valid on a free tag SHALL be ignored.
REQ-028 Simultaneous retire of tag X and classification of a request with tag X SHALL accept the request (retire has priority, busy[X] ends at 1).
REQ-029 outstanding SHALL equal the popcount of busy[3:0], registered.
REQ-030 issue_* outputs SHALL be 0 when the FIFO is empty.

Reset
REQ-031 reset=1 SHALL immediately force: FSM=IDLE, FIFO empty, pointers 0, busy=0000, outstanding=0, issue_valid=0, issue_* =0, lresp_valid=0, lresp=NORE(00), lresp_tag=0, dup_err=0, proto_err=0.
REQ-032 reset asserted mid-request (in DATA2) SHALL discard the partial request, with no push and no lresp.
REQ-033 After reset deassertion, the first rising edge SHALL be able to sample a command.

Verification
REQ-034 ADD tag1, op1=5, op2=7, issue_ready=1 -> issue_valid at T+2, issue_cmd=0001, issue_op1=5, issue_op2=7, issue_tag=01, outstanding=1.
REQ-035 cmd=0011 tag2 -> lresp_valid=1, lresp=10, lresp_tag=10 at T+2, no push, outstanding unchanged.
REQ-036 Four requests tags 0..3 with issue_ready=0, then a fifth with tag2 -> dup_err pulse, FIFO count 4, outstanding=4; then done tag2 and re-send tag2 -> accepted.
REQ-037 done_valid tag3 in the same cycle as DATA2 of SUB tag3 (tag3 busy) -> request pushed, busy[3]=1, outstanding unchanged.
REQ-038 reset pulsed during DATA2 of LSH tag0 -> no issue, no lresp, outstanding=0, following ADD tag0 is accepted normally.
REQ-039 RSH tag1 followed by non-NOP cmd in the operand2 cycle -> proto_err pulse, request still pushed with that cycle's data as op2, FSM returns to IDLE.
